imem_banked: RTL
================

# imem_banked

Parametrised, multi-bank instruction memory for the MIPS core: synchronous-read fetch port with a bank selector, plus a valid/ready loader port for writing programs at run time. After reset, or on request, a sequential clear engine fills every word with NOP (0x00000000). It sits between the PC/fetch stage and the program-loading path, and replaces the fixed two-ROM combinational instruction store.

## Interface
- DATA_W, 32: instruction word width in bits.
- ADDR_W, 9: byte-address width; words per bank DEPTH = 2^(ADDR_W-2) (128 at default).
- NUM_BANKS, 2: number of independent banks (≥1).
- BANK_W, 1: bank-select width; must satisfy 2^BANK_W ≥ NUM_BANKS.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  one-cycle pulse requesting a full memory clear.
- busy  out  1  high while the clear engine runs.
- fetch_req  in  1  fetch request.
- fetch_bank  in  BANK_W  bank to read.
- fetch_addr  in  ADDR_W  byte address.
- fetch_ready  out  1  fetch port can accept a request.
- fetch_valid  out  1  fetch_data/fetch_fault valid this cycle.
- fetch_data  out  DATA_W  instruction word.
- fetch_fault  out  1  misaligned address or bank out of range.
- load_valid  in  1  loader write request.
- load_bank  in  BANK_W  target bank.
- load_addr  in  ADDR_W  target byte address.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  loader port can accept a write.

## Operation
- Storage: NUM_BANKS × DEPTH words of DATA_W. Word index = addr[ADDR_W-1:2].
- FSM states: CLEAR, READY.
  - CLEAR: counter clr_idx runs 0..DEPTH-1, writing 0 to word clr_idx in all banks in parallel, one word per cycle. After the DEPTH-1 write, move to READY.
  - READY: ports are open. A clear_req pulse moves the FSM to CLEAR with clr_idx=0 at the next edge.
- busy = (state==CLEAR). fetch_ready = load_ready = (state==READY).
- Fetch is accepted when fetch_req & fetch_ready.
  - fault = (fetch_addr[1:0]≠0) | (fetch_bank ≥ NUM_BANKS).
  - On fault: fetch_data=0 and fetch_fault=1. Otherwise fetch_data = mem[bank][index] and fetch_fault=0.
- Load is accepted when load_valid & load_ready.
  - A misaligned address or out-of-range bank causes the write to be silently dropped.
  - load_addr[1:0] must be 0 for the write to occur; there are no partial writes.
- Fetch and load in the same cycle are both accepted. For the same bank and word, the fetch returns the old data (read-before-write).
- clear_req in the same cycle as an accepted fetch or load: both transactions complete normally, then CLEAR starts.
- clear_req while in CLEAR: ignored; no restart.

## Timing
- Reset (rst_n low, asynchronous):
  - state=CLEAR, clr_idx=0, busy=1.
  - fetch_ready=0, load_ready=0, fetch_valid=0, fetch_data=0, fetch_fault=0.
- A reset asserted mid-CLEAR restarts the clear from index 0.
- Clear duration: exactly DEPTH cycles with busy=1 after reset release or after the clear_req edge. fetch_ready rises on the following cycle.
- Fetch latency: 1 cycle. A request accepted at edge N gives fetch_valid=1 with data in the cycle after edge N.
- fetch_valid is a single-cycle pulse per accepted request. Back-to-back requests give back-to-back valid cycles at full throughput.
- When fetch_valid=0, fetch_data and fetch_fault hold their last values.
- A load written at edge N is visible to a fetch accepted at edge N+1 or later.
- Requests presented while busy=1 are not accepted; the requester must hold them.

## Test plan
- Reset release with defaults: busy=1 for 128 cycles, then fetch_ready=1. A fetch of bank 1, addr 0x1FC returns 0x00000000 with fetch_fault=0.
- Load bank0/0x004=0x8C010004 and bank1/0x004=0x20020005, then fetch each: data 0x8C010004 and 0x20020005 one cycle after acceptance, fetch_fault=0.
- Same-cycle load bank0/0x008=0xDEADBEEF with fetch bank0/0x008: the fetch returns 0x00000000; the next fetch of the same address returns 0xDEADBEEF.
- Fetch addr 0x006 → fetch_data=0, fetch_fault=1. Load at addr 0x00A → no write occurs; a fetch of 0x008 is unchanged.
- Fetch with fetch_bank=1 under NUM_BANKS=1 → fault=1, data=0.
- After loading data, pulse clear_req: busy=1 for 128 cycles, then all loaded words read 0. Asserting rst_n low at clear cycle 50 restarts the full 128-cycle clear.

Source files
------------

// File: rtl/imem_banked.sv
// imem_banked: multi-bank instruction memory with a registered fetch port,
// a valid/ready loader port and a sequential NOP-fill clear engine.
module imem_banked #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [BANK_W-1:0] fetch_bank,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_valid,
  input  logic [BANK_W-1:0] load_bank,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  load_idx;
  logic              fetch_bank_ok;
  logic              load_bank_ok;
  logic              fetch_bad;
  logic              fetch_go;
  logic              load_go;
  logic [DATA_W-1:0] rd_word;

  assign busy        = (state == CLEAR);
  assign fetch_ready = (state == READY);
  assign load_ready  = (state == READY);

  assign fetch_idx = fetch_addr[ADDR_W-1:2];
  assign load_idx  = load_addr[ADDR_W-1:2];

  assign fetch_bad = (fetch_addr[1:0] != 2'b00) | ~fetch_bank_ok;
  assign fetch_go  = fetch_req & fetch_ready;
  assign load_go   = load_valid & load_ready & load_bank_ok & (load_addr[1:0] == 2'b00);

  // Bank decode and read mux; a bank is in range only if it matches an
  // implemented bank, so the range check falls out of the decode itself.
  always_comb begin
    fetch_bank_ok = 1'b0;
    load_bank_ok  = 1'b0;
    rd_word       = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (fetch_bank == BANK_W'(b)) begin
        fetch_bank_ok = 1'b1;
        rd_word       = mem[b][fetch_idx];
      end
      if (load_bank == BANK_W'(b)) begin
        load_bank_ok = 1'b1;
      end
    end
  end

  // Control FSM: clear sweep over all word indices, then open the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state <= READY;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  // Storage writes: clear engine zeroes one word in every bank per cycle,
  // otherwise accepted loads write the addressed bank.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (state == CLEAR) begin
        mem[b][clr_idx] <= '0;
      end else if (load_go && (load_bank == BANK_W'(b))) begin
        mem[b][load_idx] <= load_data;
      end
    end
  end

  // Fetch response register; the read samples pre-write contents, so a
  // same-cycle load to the same word returns the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_valid <= fetch_go;
      if (fetch_go) begin
        fetch_fault <= fetch_bad;
        fetch_data  <= fetch_bad ? '0 : rd_word;
      end
    end
  end

endmodule
